mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single data-memory port between the CPU memory stage (loads/stores) and the VGA pixel fetcher, which today are selected by manual switches. Grants at most one requester per cycle, drives the RAM address/write port, steers the one-cycle-latency read data back to its owner with a valid strobe, and stalls the CPU while it is denied. VGA has priority for display timing; a bounded-run counter guarantees CPU forward progress.

## Interface
- WIDTH, 32, data and address width
- MAX_VGA_RUN, 3, max consecutive VGA grants while CPU waits (legal 1..15)

- CLK  in  1  clock, all state on rising edge
- RESET  in  1  asynchronous, active-low reset
- CPU_REQ  in  1  CPU memory-stage access request
- CPU_WE  in  1  1 = store, 0 = load (valid with CPU_REQ)
- CPU_ADDR  in  WIDTH  CPU byte address
- CPU_WDATA  in  WIDTH  CPU store data
- CPU_STALL  out  1  CPU request pending but not granted this cycle
- CPU_RDATA  out  WIDTH  load data
- CPU_RVALID  out  1  CPU_RDATA valid this cycle
- VGA_REQ  in  1  pixel read request
- VGA_ADDR  in  WIDTH  pixel address
- VGA_RDATA  out  WIDTH  pixel data
- VGA_RVALID  out  1  VGA_RDATA valid this cycle
- MEM_ADDR  out  WIDTH  RAM address
- MEM_WE  out  1  RAM write enable
- MEM_WDATA  out  WIDTH  RAM write data
- MEM_RDATA  in  WIDTH  RAM read data, valid one cycle after address
- OWNER  out  2  registered owner of last grant: 0 IDLE, 1 CPU, 2 VGA

## Operation
- Grant decision combinational in cycle N from CPU_REQ, VGA_REQ, run counter:
  - neither: no grant, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0
  - one requester: that one granted
  - both: VGA granted unless run_cnt == MAX_VGA_RUN, then CPU granted
- CPU grant: MEM_ADDR=CPU_ADDR, MEM_WE=CPU_WE, MEM_WDATA=CPU_WDATA. VGA grant: MEM_ADDR=VGA_ADDR, MEM_WE=0 (VGA never writes).
- CPU_STALL = CPU_REQ & ~cpu_grant (combinational); VGA has no stall output, VGA_REQ simply retried by requester.
- run_cnt (4 bits): VGA granted while CPU_REQ=1 -> +1 (saturates at MAX_VGA_RUN); CPU granted or CPU_REQ=0 -> 0.
- State machine (OWNER register), next state = grant of cycle N: IDLE (no grant), CPU, VGA. Any state may go to any other in one cycle.
- Read-return tag registered at edge ending cycle N: rd_cpu = cpu_grant & ~CPU_WE; rd_vga = vga_grant.
- Cycle N+1: CPU_RVALID=rd_cpu, VGA_RVALID=rd_vga; CPU_RDATA and VGA_RDATA both = MEM_RDATA gated to 0 when their valid is 0.
- Stores produce no RVALID. CPU_RVALID and VGA_RVALID never both 1.

## Timing
- Reset (RESET=0): OWNER=IDLE, run_cnt=0, rd tags=0, hence CPU_RVALID=VGA_RVALID=0, RDATA outputs 0; grants forced off while RESET=0 (MEM_WE=0, CPU_STALL=0).
- Reset asserted mid-access: pending return tag cleared; read data of that access discarded, no RVALID after release.
- First grant possible in first cycle with RESET=1.
- Throughput: one access per cycle, back-to-back grants to either side allowed, read latency exactly 1 cycle from grant.
- Worst-case CPU wait with VGA_REQ held high: MAX_VGA_RUN stalled cycles, granted on cycle MAX_VGA_RUN+1.
- CPU_REQ and CPU_ADDR/WE/WDATA must hold stable while CPU_STALL=1 (pipeline frozen); arbiter does not latch them.

## Test plan
- Reset: RESET=0 with both REQ high -> MEM_WE=0, CPU_STALL=0, both RVALID=0, OWNER=0; release -> VGA granted first cycle.
- CPU only: load addr 0x10, RAM returns 0xDEADBEEF -> MEM_ADDR=0x10 cycle N, CPU_RVALID=1, CPU_RDATA=0xDEADBEEF cycle N+1, no stall; store 0x20/0x55 -> MEM_WE=1, no RVALID.
- Contention, MAX_VGA_RUN=3, both REQ held: grants V,V,V,C,V,V,V,C; CPU_STALL high 3 cycles each round; OWNER sequence 2,2,2,1.
- CPU_REQ drops after 2 VGA-contended cycles then returns -> run_cnt cleared, CPU again waits full 3 cycles.
- Alternating CPU load/VGA read back-to-back -> each RVALID exactly one cycle after its grant, never simultaneous, RDATA of non-owner 0.
- RESET low in cycle after CPU load grant -> no CPU_RVALID afterwards, run_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between CPU (loads/stores) and VGA pixel reads; grant and RAM drive are combinational,
// read data returns exactly one cycle after grant. CPU is stalled while denied, VGA simply retries.
module mem_port_arbiter #(
    parameter int WIDTH       = 32,
    parameter int MAX_VGA_RUN = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cpu_req,
    input  logic             i_cpu_we,
    input  logic [WIDTH-1:0] i_cpu_addr,
    input  logic [WIDTH-1:0] i_cpu_wdata,
    output logic             o_cpu_stall,
    output logic [WIDTH-1:0] o_cpu_rdata,
    output logic             o_cpu_rvalid,
    input  logic             i_vga_req,
    input  logic [WIDTH-1:0] i_vga_addr,
    output logic [WIDTH-1:0] o_vga_rdata,
    output logic             o_vga_rvalid,
    output logic [WIDTH-1:0] o_mem_addr,
    output logic             o_mem_we,
    output logic [WIDTH-1:0] o_mem_wdata,
    input  logic [WIDTH-1:0] i_mem_rdata,
    output logic [1:0]       o_owner
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2
    } owner_e;

    localparam logic [3:0] MAX_RUN = 4'(MAX_VGA_RUN);

    owner_e     r_owner;
    owner_e     w_owner_nxt;
    logic [3:0] r_run_cnt;
    logic       r_rd_cpu;
    logic       r_rd_vga;
    logic       w_cpu_grant;
    logic       w_vga_grant;

    // Grants are suppressed while reset is held so nothing reaches the RAM.
    always_comb begin
        w_cpu_grant = 1'b0;
        w_vga_grant = 1'b0;
        w_owner_nxt = OWN_IDLE;
        o_mem_addr  = '0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        if (i_rst_n) begin
            if (i_cpu_req && (!i_vga_req || r_run_cnt == MAX_RUN)) begin
                w_cpu_grant = 1'b1;
                w_owner_nxt = OWN_CPU;
                o_mem_addr  = i_cpu_addr;
                o_mem_we    = i_cpu_we;
                o_mem_wdata = i_cpu_wdata;
            end else if (i_vga_req) begin
                w_vga_grant = 1'b1;
                w_owner_nxt = OWN_VGA;
                o_mem_addr  = i_vga_addr;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner <= OWN_IDLE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    // Counts VGA wins over a waiting CPU; any CPU grant or idle CPU restarts the run.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run_cnt <= 4'd0;
        end else if (w_vga_grant && i_cpu_req) begin
            if (r_run_cnt != MAX_RUN) begin
                r_run_cnt <= r_run_cnt + 4'd1;
            end
        end else begin
            r_run_cnt <= 4'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_cpu <= 1'b0;
            r_rd_vga <= 1'b0;
        end else begin
            r_rd_cpu <= w_cpu_grant & ~i_cpu_we;
            r_rd_vga <= w_vga_grant;
        end
    end

    assign o_cpu_stall  = i_rst_n & i_cpu_req & ~w_cpu_grant;
    assign o_cpu_rvalid = r_rd_cpu;
    assign o_vga_rvalid = r_rd_vga;
    assign o_cpu_rdata  = r_rd_cpu ? i_mem_rdata : '0;
    assign o_vga_rdata  = r_rd_vga ? i_mem_rdata : '0;
    assign o_owner      = r_owner;

endmodule
